// File: rtl/gsim_band_solver.sv
// -----------------------------------------------------------------------------
// gsim_band_solver
//
// Gauss-Seidel iterative solver for the banded symmetric Toeplitz system
//   20*x_i - 13(x_{i-1}+x_{i+1}) + 6(x_{i-2}+x_{i+2}) - (x_{i-3}+x_{i+3}) = b_i
// over N unknowns. The b vector is loaded one integer element per beat, the
// solver runs up to iter_max sweeps (optionally stopping early once the
// largest per-sweep change is within TOL LSBs), then streams x_0..x_{N-1} out
// over a ready/valid handshake. x is signed fixed point Q(X_W-FRAC).FRAC.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   in_en        b_in beat valid (honoured only while in_ready is high)
//   b_in         signed integer b element
//   iter_max     sweep limit, captured on the first beat of a system
//   in_ready     high while idle or loading
//   out_valid    x_out holds a valid solution element
//   out_ready    sink accepts x_out
//   x_out        solution element, index order 0..N-1
//   sweeps_done  sweeps executed for the current/last system
//   converged    last system stopped on the convergence test
// -----------------------------------------------------------------------------
module gsim_band_solver #(
  parameter int N          = 16,
  parameter int IN_W       = 16,
  parameter int X_W        = 32,
  parameter int FRAC       = 16,
  parameter int ITER_W     = 8,
  parameter int EARLY_EXIT = 0,
  parameter int TOL        = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_en,
  input  logic signed [IN_W-1:0]   b_in,
  input  logic        [ITER_W-1:0] iter_max,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [X_W-1:0]    x_out,
  output logic        [ITER_W-1:0] sweeps_done,
  output logic                     converged
);

  // Six guard bits: |num| <= |B| + 40*max|x| stays below 2^(X_W+5).
  localparam int NUM_W = X_W + 6;
  localparam int IDX_W = $clog2(N);
  // Neighbour window is x padded with three zeros on each side, so the
  // out-of-range neighbours need no special casing.
  localparam int PAD_N = N + 6;
  localparam int PAD_W = $clog2(PAD_N);

  localparam logic signed [NUM_W-1:0] C_1  = NUM_W'(1);
  localparam logic signed [NUM_W-1:0] C_6  = NUM_W'(6);
  localparam logic signed [NUM_W-1:0] C_13 = NUM_W'(13);
  localparam logic signed [NUM_W-1:0] C_20 = NUM_W'(20);
  localparam logic signed [NUM_W-1:0] X_MAX =
    {{(NUM_W-X_W+1){1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [NUM_W-1:0] X_MIN =
    {{(NUM_W-X_W+1){1'b1}}, {(X_W-1){1'b0}}};
  localparam logic [X_W:0] TOL_V = (X_W+1)'(TOL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CALC,
    S_CHECK,
    S_OUT
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic signed [IN_W-1:0]    r_b [N];
  logic signed [X_W-1:0]     r_x [N];
  logic        [IDX_W-1:0]   r_idx;        // load beat / unknown / output index
  logic                      r_phase;      // 0: operand read, 1: write-back
  logic signed [NUM_W-1:0]   r_num;
  logic        [X_W:0]       r_max_delta;  // max |x_new - x_old| this sweep
  logic        [ITER_W-1:0]  r_iter_max;
  logic        [ITER_W-1:0]  r_sweeps;
  logic                      r_conv;

  logic                      w_idx_last;
  logic        [ITER_W-1:0]  w_sweeps_inc;
  logic                      w_limit;
  logic                      w_early;
  logic signed [NUM_W-1:0]   w_xpad [PAD_N];
  logic        [PAD_W-1:0]   w_ctr;
  logic signed [NUM_W-1:0]   w_b_ext;
  logic signed [NUM_W-1:0]   w_num;
  logic signed [NUM_W-1:0]   w_quo;
  logic signed [NUM_W-1:0]   w_rem;
  logic signed [NUM_W-1:0]   w_floor;
  logic signed [X_W-1:0]     w_x_new;
  logic signed [X_W-1:0]     w_x_old;
  logic        [X_W:0]       w_diff;
  logic        [X_W:0]       w_abs;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_idx_last   = (r_idx == IDX_W'(N-1));
  assign w_sweeps_inc = r_sweeps + ITER_W'(1);
  assign w_limit      = (w_sweeps_inc == r_iter_max);
  assign w_early      = (EARLY_EXIT != 0) && (r_max_delta <= TOL_V);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: flops are written with non-blocking (<=) so every register samples
  // the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    x_out       = '0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_en) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_en && w_idx_last)
          w_state_nxt = (r_iter_max == '0) ? S_OUT : S_CALC;
      end
      S_CALC: begin
        if (r_phase && w_idx_last) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        w_state_nxt = (w_limit || w_early) ? S_OUT : S_CALC;
      end
      S_OUT: begin
        out_valid = 1'b1;
        x_out     = r_x[r_idx];
        if (out_ready && w_idx_last) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign sweeps_done = r_sweeps;
  assign converged   = r_conv;

  // ---------------------------------------------------------------------------
  // Numerator: B_i + 13(x-1 + x+1) - 6(x-2 + x+2) + (x-3 + x+3)
  // Lower neighbours already hold this sweep's values (Gauss-Seidel).
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int j = 0; j < PAD_N; j++) w_xpad[j] = '0;
    for (int j = 0; j < N; j++)     w_xpad[j+3] = NUM_W'(r_x[j]);
  end

  assign w_ctr   = PAD_W'(r_idx) + PAD_W'(3);
  assign w_b_ext = NUM_W'(r_b[r_idx]) <<< FRAC;
  assign w_num   = w_b_ext
                 + C_13 * (w_xpad[w_ctr - PAD_W'(1)] + w_xpad[w_ctr + PAD_W'(1)])
                 - C_6  * (w_xpad[w_ctr - PAD_W'(2)] + w_xpad[w_ctr + PAD_W'(2)])
                 +        (w_xpad[w_ctr - PAD_W'(3)] + w_xpad[w_ctr + PAD_W'(3)]);

  // ---------------------------------------------------------------------------
  // floor(num/20): '/' truncates toward zero, so a negative dividend with a
  // non-zero remainder is pulled down by one.
  // ---------------------------------------------------------------------------
  assign w_quo   = r_num / C_20;
  assign w_rem   = r_num % C_20;
  assign w_floor = (r_num[NUM_W-1] && (w_rem != '0)) ? (w_quo - C_1) : w_quo;

  always_comb begin
    w_x_new = w_floor[X_W-1:0];
    if (w_floor > X_MAX)      w_x_new = X_MAX[X_W-1:0];
    else if (w_floor < X_MIN) w_x_new = X_MIN[X_W-1:0];
  end

  // Change magnitude needs one extra bit: x_new - x_old spans 2^X_W.
  assign w_x_old = r_x[r_idx];
  assign w_diff  = {w_x_new[X_W-1], w_x_new} - {w_x_old[X_W-1], w_x_old};
  assign w_abs   = w_diff[X_W] ? -w_diff : w_diff;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: b/x storage is in the async reset on purpose: a reset must leave no
  // trace of a discarded system, so these are flops, not a RAM macro.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx       <= '0;
      r_phase     <= 1'b0;
      r_num       <= '0;
      r_max_delta <= '0;
      r_iter_max  <= '0;
      r_sweeps    <= '0;
      r_conv      <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_b[i] <= '0;
        r_x[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE, S_LOAD: begin
          if (in_en) begin
            r_b[r_idx] <= b_in;
            if (r_state == S_IDLE) begin
              // Results of the previous system are held until now.
              r_iter_max <= iter_max;
              r_sweeps   <= '0;
              r_conv     <= 1'b0;
            end
            if (w_idx_last) begin
              r_idx    <= '0;
              r_phase  <= 1'b0;
              r_sweeps <= '0;
              for (int i = 0; i < N; i++) r_x[i] <= '0;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        S_CALC: begin
          if (!r_phase) begin
            r_num   <= w_num;
            r_phase <= 1'b1;
          end else begin
            r_x[r_idx] <= w_x_new;
            // First unknown of a sweep restarts the running maximum.
            if ((r_idx == '0) || (w_abs > r_max_delta)) r_max_delta <= w_abs;
            r_phase <= 1'b0;
            r_idx   <= w_idx_last ? '0 : r_idx + IDX_W'(1);
          end
        end
        S_CHECK: begin
          r_sweeps <= w_sweeps_inc;
          if (w_early) r_conv <= 1'b1;
        end
        S_OUT: begin
          if (out_ready) r_idx <= w_idx_last ? '0 : r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_band_solver.sv
// -----------------------------------------------------------------------------
// tb_gsim_band_solver
//
// Two solver instances share one clock and reset:
//   d=0 : N=16, EARLY_EXIT=0
//   d=1 : N=4,  EARLY_EXIT=1, TOL=1
// Expected results come from a plain-arithmetic Gauss-Seidel model.
// -----------------------------------------------------------------------------
module tb_gsim_band_solver;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic               in_en       [2];
  logic signed [15:0] b_in        [2];
  logic        [7:0]  iter_max    [2];
  logic               in_ready    [2];
  logic               out_valid   [2];
  logic               out_ready   [2];
  logic        [31:0] x_out       [2];
  logic        [7:0]  sweeps_done [2];
  logic               converged   [2];

  int checks = 0;
  int fails  = 0;

  gsim_band_solver #(.N(16), .EARLY_EXIT(0)) u_dut16 (
    .clk(clk), .reset(rst_n), .in_en(in_en[0]), .b_in(b_in[0]),
    .iter_max(iter_max[0]), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .x_out(x_out[0]), .sweeps_done(sweeps_done[0]),
    .converged(converged[0])
  );

  gsim_band_solver #(.N(4), .EARLY_EXIT(1), .TOL(1)) u_dut4 (
    .clk(clk), .reset(rst_n), .in_en(in_en[1]), .b_in(b_in[1]),
    .iter_max(iter_max[1]), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .x_out(x_out[1]), .sweeps_done(sweeps_done[1]),
    .converged(converged[1])
  );

  function automatic int nof(input int d);
    return (d == 0) ? 16 : 4;
  endfunction

  // Reference: straight Gauss-Seidel on integers, floor division, saturation.
  function automatic void model(input int n, input int b[$], input int itmax,
                                input bit ee, input int tol,
                                output longint x[$], output int sw, output bit cv);
    longint xs [64];
    longint num, q, dlt, maxd;
    int coef;
    for (int i = 0; i < 64; i++) xs[i] = 0;
    sw = 0;
    cv = 1'b0;
    while (sw < itmax) begin
      maxd = 0;
      for (int i = 0; i < n; i++) begin
        num = longint'(b[i]) * 65536;
        for (int k = 1; k <= 3; k++) begin
          coef = (k == 1) ? 13 : ((k == 2) ? -6 : 1);
          if (i - k >= 0) num += coef * xs[i-k];
          if (i + k < n)  num += coef * xs[i+k];
        end
        q = (num >= 0) ? (num / 20) : -((-num + 19) / 20);
        if (q > 64'sd2147483647)  q = 64'sd2147483647;
        if (q < -64'sd2147483648) q = -64'sd2147483648;
        dlt = q - xs[i];
        if (dlt < 0) dlt = -dlt;
        if (dlt > maxd) maxd = dlt;
        xs[i] = q;
      end
      sw++;
      if (ee && (maxd <= tol)) begin
        cv = 1'b1;
        break;
      end
    end
    x = {};
    for (int i = 0; i < n; i++) x.push_back(xs[i]);
  endfunction

  // Drives all beats of b; in_en drops on the first negedge after the last
  // accepting edge. Later beats carry a junk iter_max that must be ignored.
  task automatic load_system(input int d, input int b[$], input int it, input bit gaps);
    for (int i = 0; i < b.size(); i++) begin
      @(negedge clk);
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_en[d] = 1'b0;
        @(negedge clk);
      end
      checks++;
      if (in_ready[d] !== 1'b1) begin
        fails++;
        $display("FAIL in_ready_load d=%0d beat=%0d: got %b want 1", d, i, in_ready[d]);
      end
      in_en[d]    = 1'b1;
      b_in[d]     = 16'(b[i]);
      iter_max[d] = (i == 0) ? 8'(it) : 8'($urandom_range(0, 255));
    end
    @(negedge clk);
    in_en[d] = 1'b0;
  endtask

  // Counts negedges from the last accepting edge until out_valid is seen.
  // With storm set, in_en/b_in/out_ready toggle randomly meanwhile.
  task automatic wait_output(input int d, input bit storm, output int lat);
    lat = 1;
    while ((out_valid[d] !== 1'b1) && (lat < 20000)) begin
      if (storm) begin
        in_en[d]     = 1'($urandom_range(0, 1));
        b_in[d]      = 16'($urandom_range(0, 65535));
        out_ready[d] = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    in_en[d]     = 1'b0;
    out_ready[d] = 1'b0;
    if (lat >= 20000) begin
      checks++;
      fails++;
      $display("FAIL out_valid_timeout d=%0d: no out_valid within %0d cycles", d, lat);
    end
  endtask

  // Accepts n elements (random or constant ready), monitoring stall stability
  // and the drop of out_valid / rise of in_ready after the final element.
  task automatic collect(input int d, input int n, input bit rnd, output logic [31:0] got[$]);
    int          cyc;
    bit          stalled;
    logic [31:0] held;
    got     = {};
    cyc     = 0;
    stalled = 1'b0;
    held    = '0;
    while ((got.size() < n) && (cyc < 5000)) begin
      out_ready[d] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      checks++;
      if (out_valid[d] !== 1'b1) begin
        fails++;
        $display("FAIL out_valid_stream d=%0d elem=%0d: got %b want 1", d, got.size(), out_valid[d]);
      end else begin
        if (stalled) begin
          checks++;
          if (x_out[d] !== held) begin
            fails++;
            $display("FAIL x_out_stall d=%0d: got %h want held %h", d, x_out[d], held);
          end
        end
        if (out_ready[d]) begin
          got.push_back(x_out[d]);
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = x_out[d];
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready[d] = 1'b0;
    while (got.size() < n) got.push_back('x);
    checks++;
    if ((out_valid[d] !== 1'b0) || (in_ready[d] !== 1'b1)) begin
      fails++;
      $display("FAIL stream_end d=%0d: out_valid=%b in_ready=%b want 0/1", d, out_valid[d], in_ready[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      in_en[d]     = 1'b0;
      b_in[d]      = '0;
      iter_max[d]  = '0;
      out_ready[d] = 1'b0;
    end
    #12;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1) begin
        fails++; $display("FAIL reset_in_ready d=%0d: got %b want 1", d, in_ready[d]);
      end
      checks++;
      if (out_valid[d] !== 1'b0) begin
        fails++; $display("FAIL reset_out_valid d=%0d: got %b want 0", d, out_valid[d]);
      end
      checks++;
      if (x_out[d] !== 32'h0) begin
        fails++; $display("FAIL reset_x_out d=%0d: got %h want 0", d, x_out[d]);
      end
      checks++;
      if (sweeps_done[d] !== 8'd0) begin
        fails++; $display("FAIL reset_sweeps d=%0d: got %0d want 0", d, sweeps_done[d]);
      end
      checks++;
      if (converged[d] !== 1'b0) begin
        fails++; $display("FAIL reset_converged d=%0d: got %b want 0", d, converged[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_n4_vector();
    int          b[$];
    logic [31:0] got[$];
    logic [31:0] expv[4];
    int          lat;
    b    = {20, 0, 0, 0};
    expv = '{32'h00010000, 32'h0000A666, 32'h00001F5B, 32'hFFFFEF42};
    load_system(1, b, 1, 1'b0);
    wait_output(1, 1'b0, lat);
    collect(1, 4, 1'b0, got);
    checks++;
    if (lat !== 10) begin
      fails++; $display("FAIL n4_latency: got %0d want 10", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== expv[i]) begin
        fails++; $display("FAIL n4_x[%0d]: got %h want %h", i, got[i], expv[i]);
      end
    end
    checks++;
    if ((sweeps_done[1] !== 8'd1) || (converged[1] !== 1'b0)) begin
      fails++;
      $display("FAIL n4_status: sweeps=%0d conv=%b want 1/0", sweeps_done[1], converged[1]);
    end
  endtask

  task automatic test_iter_zero();
    int          b[$];
    logic [31:0] got[$];
    int          lat;
    for (int i = 0; i < 16; i++) b.push_back(int'($urandom_range(0, 65535)) - 32768);
    load_system(0, b, 0, 1'b0);
    wait_output(0, 1'b0, lat);
    collect(0, 16, 1'b0, got);
    checks++;
    if (lat !== 1) begin
      fails++; $display("FAIL iter0_latency: got %0d want 1", lat);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'h0) begin
        fails++; $display("FAIL iter0_x[%0d]: got %h want 0", i, got[i]);
      end
    end
    checks++;
    if (sweeps_done[0] !== 8'd0) begin
      fails++; $display("FAIL iter0_sweeps: got %0d want 0", sweeps_done[0]);
    end
  endtask

  task automatic test_golden();
    int          b[$];
    logic [31:0] got[$];
    longint      mx[$];
    int          msw;
    bit          mcv;
    int          lat;
    b = {100, -250, 37, 4000, -1, 0, 812, -9999, 32767, -32768, 5, 64, -128, 7, 300, -42};
    model(16, b, 120, 1'b0, 1, mx, msw, mcv);
    load_system(0, b, 120, 1'b1);
    wait_output(0, 1'b0, lat);
    collect(0, 16, 1'b0, got);
    checks++;
    if (lat !== 120 * 33 + 1) begin
      fails++; $display("FAIL golden_latency: got %0d want %0d", lat, 120 * 33 + 1);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'(mx[i])) begin
        fails++; $display("FAIL golden_x[%0d]: got %h want %h", i, got[i], 32'(mx[i]));
      end
    end
    checks++;
    if ((sweeps_done[0] !== 8'd120) || (converged[0] !== 1'b0)) begin
      fails++;
      $display("FAIL golden_status: sweeps=%0d conv=%b want 120/0", sweeps_done[0], converged[0]);
    end
  endtask

  task automatic test_early_exit();
    int          b[$];
    logic [31:0] got[$];
    longint      mx[$];
    int          msw;
    bit          mcv;
    int          lat;
    b = {0, 0, 0, 0};
    load_system(1, b, 200, 1'b0);
    wait_output(1, 1'b0, lat);
    collect(1, 4, 1'b1, got);
    checks++;
    if (lat !== 10) begin
      fails++; $display("FAIL ee_latency: got %0d want 10", lat);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== 32'h0) begin
        fails++; $display("FAIL ee_x[%0d]: got %h want 0", i, got[i]);
      end
    end
    // Status holds through idle cycles until the next system's first beat.
    repeat (3) @(negedge clk);
    checks++;
    if ((sweeps_done[1] !== 8'd1) || (converged[1] !== 1'b1)) begin
      fails++;
      $display("FAIL ee_status_hold: sweeps=%0d conv=%b want 1/1", sweeps_done[1], converged[1]);
    end
    b = {};
    for (int i = 0; i < 4; i++) b.push_back(int'($urandom_range(0, 400)) - 200);
    in_en[1]    = 1'b1;
    b_in[1]     = 16'(b[0]);
    iter_max[1] = 8'd2;
    @(negedge clk);
    in_en[1] = 1'b0;
    checks++;
    if ((sweeps_done[1] !== 8'd0) || (converged[1] !== 1'b0)) begin
      fails++;
      $display("FAIL ee_status_clear: sweeps=%0d conv=%b want 0/0", sweeps_done[1], converged[1]);
    end
    load_system(1, b[1:$], 2, 1'b0);
    model(4, b, 2, 1'b1, 1, mx, msw, mcv);
    wait_output(1, 1'b0, lat);
    collect(1, 4, 1'b0, got);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got[i] !== 32'(mx[i])) begin
        fails++; $display("FAIL ee_next_x[%0d]: got %h want %h", i, got[i], 32'(mx[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    int          b[$];
    logic [31:0] got[$];
    longint      mx[$];
    int          msw;
    bit          mcv;
    int          lat;
    int          it;
    int          n;
    int          span;
    for (int d = 0; d < 2; d++) begin
      n    = nof(d);
      span = (d == 0) ? 32767 : 200;
      for (int k = 0; k < ((d == 0) ? 4 : 8); k++) begin
        b = {};
        for (int i = 0; i < n; i++) b.push_back(int'($urandom_range(0, 2 * span)) - span);
        it = (d == 0) ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 40));
        model(n, b, it, d == 1, 1, mx, msw, mcv);
        load_system(d, b, it, 1'b1);
        wait_output(d, 1'b1, lat);
        collect(d, n, 1'b1, got);
        checks++;
        if (lat !== msw * (2 * n + 1) + 1) begin
          fails++;
          $display("FAIL bp_latency d=%0d run=%0d: got %0d want %0d", d, k, lat, msw * (2 * n + 1) + 1);
        end
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got[i] !== 32'(mx[i])) begin
            fails++;
            $display("FAIL bp_x d=%0d run=%0d [%0d]: got %h want %h", d, k, i, got[i], 32'(mx[i]));
          end
        end
        checks++;
        if ((sweeps_done[d] !== 8'(msw)) || (converged[d] !== mcv)) begin
          fails++;
          $display("FAIL bp_status d=%0d run=%0d: sweeps=%0d conv=%b want %0d/%b",
                   d, k, sweeps_done[d], converged[d], msw, mcv);
        end
      end
    end
  endtask

  task automatic test_reset_async();
    int          b[$];
    logic [31:0] got[$];
    longint      mx[$];
    int          msw;
    bit          mcv;
    int          lat;
    bit          seen;
    for (int i = 0; i < 16; i++) b.push_back(int'($urandom_range(0, 2000)) - 1000);
    load_system(0, b, 50, 1'b0);
    repeat (100) @(negedge clk);
    checks++;
    if ((sweeps_done[0] !== 8'd3) || (out_valid[0] !== 1'b0)) begin
      fails++;
      $display("FAIL mid_calc: sweeps=%0d out_valid=%b want 3/0", sweeps_done[0], out_valid[0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ((out_valid[0] !== 1'b0) || (in_ready[0] !== 1'b1) || (sweeps_done[0] !== 8'd0)) begin
      fails++;
      $display("FAIL async_reset: out_valid=%b in_ready=%b sweeps=%0d want 0/1/0",
               out_valid[0], in_ready[0], sweeps_done[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid[0] === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      fails++; $display("FAIL post_reset_valid: got out_valid=1 want 0");
    end
    // Release with the first beat already present: it must be accepted on
    // the first edge after release.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    b = {};
    for (int i = 0; i < 16; i++) b.push_back(int'($urandom_range(0, 2000)) - 1000);
    @(negedge clk);
    rst_n       = 1'b1;
    in_en[0]    = 1'b1;
    b_in[0]     = 16'(b[0]);
    iter_max[0] = 8'd3;
    load_system(0, b[1:$], 3, 1'b0);
    model(16, b, 3, 1'b0, 1, mx, msw, mcv);
    wait_output(0, 1'b0, lat);
    collect(0, 16, 1'b1, got);
    checks++;
    if (lat !== 3 * 33 + 1) begin
      fails++; $display("FAIL reload_latency: got %0d want %0d", lat, 3 * 33 + 1);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (got[i] !== 32'(mx[i])) begin
        fails++; $display("FAIL reload_x[%0d]: got %h want %h", i, got[i], 32'(mx[i]));
      end
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_n4_vector();
    test_iter_zero();
    test_golden();
    test_early_exit();
    test_backpressure();
    test_reset_async();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
